dma_ctrl: RTL and testbench
===========================

# dma_ctrl

Instruction decoder and counter sequencer for the Am2940-style DMA address generator. It holds the control, address and word-count registers and counters, decodes the 3-bit microprocessor instruction stream, and steps the counters on each transfer strobe. It drives the `done_gen` comparison inputs (`doac`, `dowc`, `dowr`, `mode`, `cinw`) and uses the returned `done` to stop the transfer.

## Interface
- Parameters: none (8-bit datapath fixed).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `instr_vld` in 1: `instr` is valid this cycle.
- `instr` in 3: instruction code, see Operation.
- `d_in` in 8: data bus for load instructions.
- `cnt_step` in 1: transfer strobe; advances the counters when enabled.
- `done` in 1: terminal flag from `done_gen`; combinational from the current counter values.
- `d_out` out 8: registered read-back data.
- `d_oe` out 1: `d_out` valid, one-cycle pulse.
- `addr_out` out 8: current address counter.
- `doac` out 8: address counter, to `done_gen`.
- `dowc` out 8: word counter, to `done_gen`.
- `dowr` out 8: word count register, to `done_gen`.
- `mode` out 2: `ctrl[1:0]`.
- `cinw` out 1: `ctrl[3]`.
- `busy` out 1: counting enabled (`cnt_en`).
- `done_out` out 1: `done` gated by mode, i.e. 0 in mode 3.

## Operation
- State:
  - `ctrl[3:0]`: `[1:0]` mode, `[2]` address direction (0 = increment, 1 = decrement), `[3]` cinw.
  - `addr_reg`, `addr_cnt`, `wc_reg`, `wc_cnt`: 8 bits each.
  - `cnt_en`: 1 bit.
- Instructions, acted on only when `instr_vld` = 1:
  - 0 WRCR: `ctrl <= d_in[3:0]`.
  - 1 RDCR: `d_out <= {4'b0, ctrl}`.
  - 2 RDWC: `d_out <= wc_cnt`.
  - 3 RDAC: `d_out <= addr_cnt`.
  - 4 REINIT: `addr_cnt <= addr_reg`. `wc_cnt <= wc_reg` in modes 0, 2, 3; `wc_cnt <= 0` in mode 1.
  - 5 LDADDR: `addr_reg <= d_in`, `addr_cnt <= d_in`.
  - 6 LDWC: `wc_reg <= d_in`. `wc_cnt <= d_in` in modes 0, 2, 3; `wc_cnt <= 0` in mode 1.
  - 7 ENCNT: `cnt_en <= 1`.
- Any valid instruction other than ENCNT clears `cnt_en`.
- Counting occurs when `cnt_en` = 1, `cnt_step` = 1, `instr_vld` = 0 and `done_out` = 0:
  - Address: `addr_cnt` ±1 per `ctrl[2]`.
  - Word counter:
    - mode 0: `wc_cnt - 1`
    - mode 1: `wc_cnt + 1`
    - mode 2: hold (`wc_reg`/`wc_cnt` are the compare address)
    - mode 3: hold
  - All counter arithmetic is modulo 256; wrap-around is silent.
- Termination:
  - `done_out = done & (mode != 3)`.
  - When `done_out` = 1 with `cnt_en` = 1, `cnt_en` clears on that edge.
  - A step in that cycle is ignored, so the counters freeze at the terminal value.
  - Mode 3 never terminates; only an instruction stops it.
- Changing `ctrl` by WRCR takes effect on the following cycle. It does not alter the counter contents.

## Timing
- Reset (`rst_n` = 0 at an edge): all registers, counters and `ctrl` go to 0; `cnt_en` = 0, `d_out` = 0, `d_oe` = 0.
  - Reset overrides any instruction or step in the same cycle.
  - Reset mid-transfer aborts it; no residual count.
- Loads, WRCR, REINIT: result visible the cycle after `instr_vld`.
- Reads: `d_out` and `d_oe` = 1 the cycle after the read instruction. `d_oe` returns to 0 the next cycle unless another read follows. `d_out` holds its last value.
- ENCNT at cycle N: steps are accepted from cycle N+1. Each accepted step updates the counters at that edge.
- Instruction and `cnt_step` in the same cycle: the instruction wins and the step is dropped.
- `doac`/`dowc`/`dowr`/`addr_out` are direct register outputs. `done`/`done_out` are combinational over them, with no added latency.

## Test plan
- **Reset.** Apply reset mid-count in mode 1 with `wc_cnt` = 5 → next cycle all outputs 0, `busy` = 0; `cnt_step` then has no effect.
- **Mode 0, cinw = 0.** Steps: WRCR 0x0, LDADDR 0x10, LDWC 0x03, ENCNT, then continuous `cnt_step`, with `done_gen` modelled as `done = (dowc == 1)`.
  - `addr_out` goes 0x11, 0x12; `dowc` goes 2, 1.
  - `done_out` = 1 when `dowc` = 1; `busy` drops the same edge.
  - Counters stay at 0x12 / 1.
- **Mode 1, increment.** Steps: WRCR 0x1, LDWC 0x04 (so `dowc` = 0, `dowr` = 4), ENCNT, steps, with `done = (dowc + 1 == dowr)`.
  - Terminates at `dowc` = 3 after 3 steps.
  - REINIT then gives `dowc` = 0.
- **Mode 2, decrementing address.** Steps: WRCR 0x6, LDADDR 0x01, LDWC 0xFE, ENCNT, steps, with `done = (dowc == doac)`.
  - `addr_out` wraps 0x00 → 0xFF → 0xFE.
  - Done after 3 steps; `dowc` stays 0xFE.
- **Mode 3 and collision.** In mode 3, 300 steps → `done_out` stays 0 and `addr_out` wraps past 0xFF.
  - RDAC together with `cnt_step` → step dropped, `busy` = 0.
  - `d_oe` pulses one cycle with `d_out` = `addr_out`.
- **Read-back.** WRCR 0xB, then RDCR, RDWC, RDAC back to back → `d_out` = 0x0B, `wc_cnt`, `addr_cnt` on three consecutive cycles, with `d_oe` held at 1 for those three cycles.

Source files
------------

// File: rtl/dma_ctrl_if.sv
// Bus bundle between the DMA sequencer and its host/done_gen side.
interface dma_ctrl_if;
    logic       instr_vld;
    logic [2:0] instr;
    logic [7:0] d_in;
    logic       cnt_step;
    logic       done;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] addr_out;
    logic [7:0] doac;
    logic [7:0] dowc;
    logic [7:0] dowr;
    logic [1:0] mode;
    logic       cinw;
    logic       busy;
    logic       done_out;

    // Host / done_gen side
    modport master (
        output instr_vld, instr, d_in, cnt_step, done,
        input  d_out, d_oe, addr_out, doac, dowc, dowr, mode, cinw, busy, done_out
    );

    // Sequencer side
    modport slave (
        input  instr_vld, instr, d_in, cnt_step, done,
        output d_out, d_oe, addr_out, doac, dowc, dowr, mode, cinw, busy, done_out
    );
endinterface

// File: rtl/dma_ctrl.sv
// Am2940-style DMA instruction decoder and address/word-count sequencer.
module dma_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    dma_ctrl_if.slave  bus
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        OP_WRCR   = 3'd0,
        OP_RDCR   = 3'd1,
        OP_RDWC   = 3'd2,
        OP_RDAC   = 3'd3,
        OP_REINIT = 3'd4,
        OP_LDADDR = 3'd5,
        OP_LDWC   = 3'd6,
        OP_ENCNT  = 3'd7
    } op_e;

    logic [CW-1:0] ctrl,     ctrl_nxt;
    logic [DW-1:0] addr_reg, addr_reg_nxt;
    logic [DW-1:0] addr_cnt, addr_cnt_nxt;
    logic [DW-1:0] wc_reg,   wc_reg_nxt;
    logic [DW-1:0] wc_cnt,   wc_cnt_nxt;
    logic          cnt_en,   cnt_en_nxt;
    logic [DW-1:0] d_out_q,  d_out_nxt;
    logic          d_oe_q,   d_oe_nxt;

    logic [1:0]    mode;
    logic          mode_wc_clear;
    logic          done_out;
    logic          step_ok;

    assign mode          = ctrl[1:0];
    assign mode_wc_clear = (mode == 2'd1);
    assign done_out      = bus.done & (mode != 2'd3);
    assign step_ok       = cnt_en & bus.cnt_step & ~bus.instr_vld & ~done_out;

    // Register bank with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl     <= '0;
            addr_reg <= '0;
            addr_cnt <= '0;
            wc_reg   <= '0;
            wc_cnt   <= '0;
            cnt_en   <= 1'b0;
            d_out_q  <= '0;
            d_oe_q   <= 1'b0;
        end else begin
            ctrl     <= ctrl_nxt;
            addr_reg <= addr_reg_nxt;
            addr_cnt <= addr_cnt_nxt;
            wc_reg   <= wc_reg_nxt;
            wc_cnt   <= wc_cnt_nxt;
            cnt_en   <= cnt_en_nxt;
            d_out_q  <= d_out_nxt;
            d_oe_q   <= d_oe_nxt;
        end
    end

    // Instruction decode and counter stepping; an instruction always beats a step
    always_comb begin
        ctrl_nxt     = ctrl;
        addr_reg_nxt = addr_reg;
        addr_cnt_nxt = addr_cnt;
        wc_reg_nxt   = wc_reg;
        wc_cnt_nxt   = wc_cnt;
        cnt_en_nxt   = cnt_en;
        d_out_nxt    = d_out_q;
        d_oe_nxt     = 1'b0;

        if (bus.instr_vld) begin
            cnt_en_nxt = 1'b0;
            case (op_e'(bus.instr))
                OP_WRCR: ctrl_nxt = bus.d_in[CW-1:0];
                OP_RDCR: begin
                    d_out_nxt = DW'({4'b0000, ctrl});
                    d_oe_nxt  = 1'b1;
                end
                OP_RDWC: begin
                    d_out_nxt = wc_cnt;
                    d_oe_nxt  = 1'b1;
                end
                OP_RDAC: begin
                    d_out_nxt = addr_cnt;
                    d_oe_nxt  = 1'b1;
                end
                OP_REINIT: begin
                    addr_cnt_nxt = addr_reg;
                    wc_cnt_nxt   = mode_wc_clear ? '0 : wc_reg;
                end
                OP_LDADDR: begin
                    addr_reg_nxt = bus.d_in;
                    addr_cnt_nxt = bus.d_in;
                end
                OP_LDWC: begin
                    wc_reg_nxt = bus.d_in;
                    wc_cnt_nxt = mode_wc_clear ? '0 : bus.d_in;
                end
                OP_ENCNT: cnt_en_nxt = 1'b1;
                default: ;
            endcase
        end else begin
            if (step_ok) begin
                addr_cnt_nxt = ctrl[2] ? addr_cnt - DW'(1) : addr_cnt + DW'(1);
                case (mode)
                    2'd0:    wc_cnt_nxt = wc_cnt - DW'(1);
                    2'd1:    wc_cnt_nxt = wc_cnt + DW'(1);
                    default: wc_cnt_nxt = wc_cnt;
                endcase
            end
            // Terminal count stops the transfer on this edge
            if (cnt_en && done_out) begin
                cnt_en_nxt = 1'b0;
            end
        end
    end

    assign bus.d_out    = d_out_q;
    assign bus.d_oe     = d_oe_q;
    assign bus.addr_out = addr_cnt;
    assign bus.doac     = addr_cnt;
    assign bus.dowc     = wc_cnt;
    assign bus.dowr     = wc_reg;
    assign bus.mode     = mode;
    assign bus.cinw     = ctrl[3];
    assign bus.busy     = cnt_en;
    assign bus.done_out = done_out;
endmodule

// File: tb/tb_dma_ctrl.sv
// Directed self-checking bench for dma_ctrl with a behavioural done_gen.
module tb_dma_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_kind;

    dma_ctrl_if bus ();

    dma_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // done_gen stand-in; kind 3 forces done high to exercise mode-3 gating
    always_comb begin
        case (done_kind)
            0:       bus.done = (bus.dowc == 8'd1);
            1:       bus.done = (8'(bus.dowc + 8'd1) == bus.dowr);
            2:       bus.done = (bus.dowc == bus.doac);
            default: bus.done = 1'b1;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [2:0] op, input logic [7:0] data);
        bus.instr_vld = 1'b1;
        bus.instr     = op;
        bus.d_in      = data;
        tick();
        bus.instr_vld = 1'b0;
        bus.instr     = 3'd0;
        bus.d_in      = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.addr_out !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h exp 00", bus.addr_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
        checks++; if (bus.d_oe !== 1'b0) begin errors++; $display("FAIL rst_doe: got %b exp 0", bus.d_oe); end
        rst_n = 1'b1;
        tick();
        // Get a mode-1 transfer running to wc_cnt = 5, then reset it mid-count
        done_kind = 1;
        do_instr(3'd0, 8'h01);
        do_instr(3'd6, 8'h10);
        do_instr(3'd5, 8'h20);
        do_instr(3'd7, 8'h00);
        bus.cnt_step = 1'b1;
        repeat (5) tick();
        checks++; if (bus.dowc !== 8'h05) begin errors++; $display("FAIL pre_rst_dowc: got %h exp 05", bus.dowc); end
        checks++; if (bus.addr_out !== 8'h25) begin errors++; $display("FAIL pre_rst_addr: got %h exp 25", bus.addr_out); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.addr_out !== 8'h00) begin errors++; $display("FAIL midrst_addr: got %h exp 00", bus.addr_out); end
        checks++; if (bus.dowc !== 8'h00) begin errors++; $display("FAIL midrst_dowc: got %h exp 00", bus.dowc); end
        checks++; if (bus.dowr !== 8'h00) begin errors++; $display("FAIL midrst_dowr: got %h exp 00", bus.dowr); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL midrst_mode: got %0d exp 0", bus.mode); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b exp 0", bus.busy); end
        checks++; if (bus.d_out !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h exp 00", bus.d_out); end
        repeat (3) tick();
        bus.cnt_step = 1'b0;
        checks++; if (bus.addr_out !== 8'h00) begin errors++; $display("FAIL postrst_addr: got %h exp 00", bus.addr_out); end
        checks++; if (bus.dowc !== 8'h00) begin errors++; $display("FAIL postrst_dowc: got %h exp 00", bus.dowc); end
    endtask

    task automatic test_mode0();
        done_kind = 0;
        do_instr(3'd0, 8'h00);
        do_instr(3'd5, 8'h10);
        do_instr(3'd6, 8'h03);
        do_instr(3'd7, 8'h00);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL m0_busy: got %b exp 1", bus.busy); end
        checks++; if (bus.dowc !== 8'h03) begin errors++; $display("FAIL m0_dowc0: got %h exp 03", bus.dowc); end
        bus.cnt_step = 1'b1;
        tick();
        checks++; if (bus.addr_out !== 8'h11) begin errors++; $display("FAIL m0_addr1: got %h exp 11", bus.addr_out); end
        checks++; if (bus.dowc !== 8'h02) begin errors++; $display("FAIL m0_dowc1: got %h exp 02", bus.dowc); end
        checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL m0_done1: got %b exp 0", bus.done_out); end
        tick();
        checks++; if (bus.addr_out !== 8'h12) begin errors++; $display("FAIL m0_addr2: got %h exp 12", bus.addr_out); end
        checks++; if (bus.dowc !== 8'h01) begin errors++; $display("FAIL m0_dowc2: got %h exp 01", bus.dowc); end
        checks++; if (bus.done_out !== 1'b1) begin errors++; $display("FAIL m0_done2: got %b exp 1", bus.done_out); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL m0_busy2: got %b exp 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL m0_busy3: got %b exp 0", bus.busy); end
        checks++; if (bus.addr_out !== 8'h12) begin errors++; $display("FAIL m0_addr3: got %h exp 12", bus.addr_out); end
        repeat (2) tick();
        bus.cnt_step = 1'b0;
        checks++; if (bus.addr_out !== 8'h12) begin errors++; $display("FAIL m0_freeze_addr: got %h exp 12", bus.addr_out); end
        checks++; if (bus.dowc !== 8'h01) begin errors++; $display("FAIL m0_freeze_dowc: got %h exp 01", bus.dowc); end
    endtask

    task automatic test_mode1();
        done_kind = 1;
        do_instr(3'd0, 8'h01);
        do_instr(3'd6, 8'h04);
        checks++; if (bus.dowc !== 8'h00) begin errors++; $display("FAIL m1_ldwc_dowc: got %h exp 00", bus.dowc); end
        checks++; if (bus.dowr !== 8'h04) begin errors++; $display("FAIL m1_ldwc_dowr: got %h exp 04", bus.dowr); end
        do_instr(3'd7, 8'h00);
        bus.cnt_step = 1'b1;
        tick();
        tick();
        checks++; if (bus.dowc !== 8'h02) begin errors++; $display("FAIL m1_dowc2: got %h exp 02", bus.dowc); end
        checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL m1_done2: got %b exp 0", bus.done_out); end
        tick();
        checks++; if (bus.dowc !== 8'h03) begin errors++; $display("FAIL m1_dowc3: got %h exp 03", bus.dowc); end
        checks++; if (bus.done_out !== 1'b1) begin errors++; $display("FAIL m1_done3: got %b exp 1", bus.done_out); end
        repeat (2) tick();
        bus.cnt_step = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL m1_busy: got %b exp 0", bus.busy); end
        checks++; if (bus.dowc !== 8'h03) begin errors++; $display("FAIL m1_freeze: got %h exp 03", bus.dowc); end
        do_instr(3'd4, 8'h00);
        checks++; if (bus.dowc !== 8'h00) begin errors++; $display("FAIL m1_reinit_dowc: got %h exp 00", bus.dowc); end
        checks++; if (bus.addr_out !== 8'h10) begin errors++; $display("FAIL m1_reinit_addr: got %h exp 10", bus.addr_out); end
    endtask

    task automatic test_mode2();
        done_kind = 2;
        do_instr(3'd0, 8'h06);
        do_instr(3'd5, 8'h01);
        do_instr(3'd6, 8'hFE);
        checks++; if (bus.dowc !== 8'hFE) begin errors++; $display("FAIL m2_ldwc: got %h exp fe", bus.dowc); end
        do_instr(3'd7, 8'h00);
        bus.cnt_step = 1'b1;
        tick();
        checks++; if (bus.addr_out !== 8'h00) begin errors++; $display("FAIL m2_addr1: got %h exp 00", bus.addr_out); end
        tick();
        checks++; if (bus.addr_out !== 8'hFF) begin errors++; $display("FAIL m2_addr2: got %h exp ff", bus.addr_out); end
        checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL m2_done2: got %b exp 0", bus.done_out); end
        tick();
        checks++; if (bus.addr_out !== 8'hFE) begin errors++; $display("FAIL m2_addr3: got %h exp fe", bus.addr_out); end
        checks++; if (bus.done_out !== 1'b1) begin errors++; $display("FAIL m2_done3: got %b exp 1", bus.done_out); end
        repeat (2) tick();
        bus.cnt_step = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL m2_busy: got %b exp 0", bus.busy); end
        checks++; if (bus.addr_out !== 8'hFE) begin errors++; $display("FAIL m2_freeze: got %h exp fe", bus.addr_out); end
        checks++; if (bus.dowc !== 8'hFE) begin errors++; $display("FAIL m2_dowc: got %h exp fe", bus.dowc); end
    endtask

    task automatic test_mode3_collision();
        done_kind = 3;
        do_instr(3'd0, 8'h03);
        do_instr(3'd5, 8'h80);
        do_instr(3'd6, 8'h05);
        do_instr(3'd7, 8'h00);
        bus.cnt_step = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++;
            if (bus.done_out !== 1'b0) begin
                errors++;
                $display("FAIL m3_done step %0d: got %b exp 0", i, bus.done_out);
            end
        end
        checks++; if (bus.addr_out !== 8'hAC) begin errors++; $display("FAIL m3_addr: got %h exp ac", bus.addr_out); end
        checks++; if (bus.dowc !== 8'h05) begin errors++; $display("FAIL m3_dowc: got %h exp 05", bus.dowc); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL m3_busy: got %b exp 1", bus.busy); end
        // RDAC while cnt_step is still high: step dropped, counting stops
        do_instr(3'd3, 8'h00);
        checks++; if (bus.addr_out !== 8'hAC) begin errors++; $display("FAIL col_addr: got %h exp ac", bus.addr_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL col_busy: got %b exp 0", bus.busy); end
        checks++; if (bus.d_oe !== 1'b1) begin errors++; $display("FAIL col_doe: got %b exp 1", bus.d_oe); end
        checks++; if (bus.d_out !== 8'hAC) begin errors++; $display("FAIL col_dout: got %h exp ac", bus.d_out); end
        tick();
        bus.cnt_step = 1'b0;
        checks++; if (bus.d_oe !== 1'b0) begin errors++; $display("FAIL col_doe_drop: got %b exp 0", bus.d_oe); end
        checks++; if (bus.d_out !== 8'hAC) begin errors++; $display("FAIL col_dout_hold: got %h exp ac", bus.d_out); end
        checks++; if (bus.addr_out !== 8'hAC) begin errors++; $display("FAIL col_addr_hold: got %h exp ac", bus.addr_out); end
    endtask

    task automatic test_back_to_back();
        do_instr(3'd0, 8'h0B);
        checks++; if (bus.cinw !== 1'b1) begin errors++; $display("FAIL rb_cinw: got %b exp 1", bus.cinw); end
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL rb_mode: got %0d exp 3", bus.mode); end
        checks++; if (bus.addr_out !== 8'hAC) begin errors++; $display("FAIL rb_wrcr_addr: got %h exp ac", bus.addr_out); end
        do_instr(3'd1, 8'h00);
        checks++; if (bus.d_out !== 8'h0B) begin errors++; $display("FAIL rb_rdcr: got %h exp 0b", bus.d_out); end
        checks++; if (bus.d_oe !== 1'b1) begin errors++; $display("FAIL rb_oe1: got %b exp 1", bus.d_oe); end
        do_instr(3'd2, 8'h00);
        checks++; if (bus.d_out !== 8'h05) begin errors++; $display("FAIL rb_rdwc: got %h exp 05", bus.d_out); end
        checks++; if (bus.d_oe !== 1'b1) begin errors++; $display("FAIL rb_oe2: got %b exp 1", bus.d_oe); end
        do_instr(3'd3, 8'h00);
        checks++; if (bus.d_out !== 8'hAC) begin errors++; $display("FAIL rb_rdac: got %h exp ac", bus.d_out); end
        checks++; if (bus.d_oe !== 1'b1) begin errors++; $display("FAIL rb_oe3: got %b exp 1", bus.d_oe); end
        tick();
        checks++; if (bus.d_oe !== 1'b0) begin errors++; $display("FAIL rb_oe_end: got %b exp 0", bus.d_oe); end
        checks++; if (bus.d_out !== 8'hAC) begin errors++; $display("FAIL rb_hold: got %h exp ac", bus.d_out); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        done_kind     = 0;
        rst_n         = 1'b0;
        bus.instr_vld = 1'b0;
        bus.instr     = 3'd0;
        bus.d_in      = 8'h00;
        bus.cnt_step  = 1'b0;
        test_reset();
        test_mode0();
        test_mode1();
        test_mode2();
        test_mode3_collision();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
